// File: rtl/branch_predictor_if.sv
// ----------------------------------------------------------------------------
// branch_predictor_if
//   Bundles the fetch-side lookup port, the execute-side update port and the
//   performance counters of the branch predictor.
//   master : fetch/execute pipeline side (drives if_pc and upd_*)
//   slave  : branch_predictor (drives predictions, redirect and statistics)
//   Lookup   : if_pc -> pred_hit, pred_taken, pred_npc
//   Update   : upd_valid, upd_pc, upd_taken, upd_target, upd_pred_taken,
//              upd_pred_npc -> mispredict, redirect_pc
//   Counters : stat_lookups, stat_mispred (STAT_W bits each)
// ----------------------------------------------------------------------------
interface branch_predictor_if #(
    parameter int STAT_W = 16
);
    logic [31:0]       if_pc;
    logic              pred_hit;
    logic              pred_taken;
    logic [31:0]       pred_npc;

    logic              upd_valid;
    logic [31:0]       upd_pc;
    logic              upd_taken;
    logic [31:0]       upd_target;
    logic              upd_pred_taken;
    logic [31:0]       upd_pred_npc;
    logic              mispredict;
    logic [31:0]       redirect_pc;

    logic [STAT_W-1:0] stat_lookups;
    logic [STAT_W-1:0] stat_mispred;

    modport master (
        output if_pc, upd_valid, upd_pc, upd_taken, upd_target,
               upd_pred_taken, upd_pred_npc,
        input  pred_hit, pred_taken, pred_npc, mispredict, redirect_pc,
               stat_lookups, stat_mispred
    );

    modport slave (
        input  if_pc, upd_valid, upd_pc, upd_taken, upd_target,
               upd_pred_taken, upd_pred_npc,
        output pred_hit, pred_taken, pred_npc, mispredict, redirect_pc,
               stat_lookups, stat_mispred
    );
endinterface

// File: rtl/branch_predictor.sv
// ----------------------------------------------------------------------------
// branch_predictor
//   Direct-mapped branch target buffer with per-entry saturating direction
//   counters. The fetch stage looks up the fetch PC every cycle and receives a
//   next-PC guess with zero latency; the execute stage reports resolved
//   control instructions, which train the table, raise mispredict and supply
//   the redirect PC. Two saturating counters track resolved instructions and
//   mispredicts.
//   Ports:
//     CLK : clock, rising edge
//     RST : synchronous reset, active-high (has priority over updates)
//     bp  : branch_predictor_if.slave (lookup, update and statistics)
// ----------------------------------------------------------------------------
module branch_predictor #(
    parameter int ENTRIES = 16,
    parameter int CTR_W   = 2,
    parameter int STAT_W  = 16
) (
    input  logic              CLK,
    input  logic              RST,
    branch_predictor_if.slave bp
);
    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = 32 - IDX_W - 2;

    localparam logic [CTR_W-1:0] CTR_MAX     = '1;
    localparam logic [CTR_W-1:0] CTR_WEAK_T  = CTR_W'(1) << (CTR_W - 1);
    localparam logic [CTR_W-1:0] CTR_WEAK_NT = CTR_WEAK_T - CTR_W'(1);

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic [31:0]      target;
        logic [CTR_W-1:0] ctr;
    } entry_t;

    localparam entry_t ENTRY_RST = '{valid: 1'b0, tag: '0, target: '0, ctr: CTR_WEAK_NT};

    entry_t            btb_q [ENTRIES];
    logic [STAT_W-1:0] stat_lookups_q;
    logic [STAT_W-1:0] stat_mispred_q;

    // Word-offset bits of the PCs carry no information for indexing or tagging.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{bp.if_pc[1:0], bp.upd_pc[1:0]};

    // ---------------- lookup (purely combinational from registered table) ----
    logic [IDX_W-1:0] if_idx;
    entry_t           if_entry;
    logic             if_hit;

    assign if_idx   = bp.if_pc[IDX_W+1:2];
    assign if_entry = btb_q[if_idx];
    assign if_hit   = if_entry.valid && (if_entry.tag == bp.if_pc[31:IDX_W+2]);

    assign bp.pred_hit   = if_hit;
    assign bp.pred_taken = if_hit && if_entry.ctr[CTR_W-1];
    assign bp.pred_npc   = bp.pred_taken ? if_entry.target : bp.if_pc + 32'd4;

    // ---------------- resolution ---------------------------------------------
    assign bp.mispredict  = bp.upd_valid &&
                            ((bp.upd_taken != bp.upd_pred_taken) ||
                             (bp.upd_taken && (bp.upd_target != bp.upd_pred_npc)));
    assign bp.redirect_pc = bp.upd_taken ? bp.upd_target : bp.upd_pc + 32'd4;

    // ---------------- update next-state --------------------------------------
    logic [IDX_W-1:0] upd_idx;
    logic [TAG_W-1:0] upd_tag;
    entry_t           upd_entry;
    entry_t           new_entry;
    logic             upd_hit;
    logic             write_en;

    assign upd_idx   = bp.upd_pc[IDX_W+1:2];
    assign upd_tag   = bp.upd_pc[31:IDX_W+2];
    assign upd_entry = btb_q[upd_idx];
    assign upd_hit   = upd_entry.valid && (upd_entry.tag == upd_tag);

    // NOTE: defaults first so every path assigns every output -- no latch.
    always_comb begin
        new_entry = upd_entry;
        write_en  = 1'b0;
        if (bp.upd_valid) begin
            if (upd_hit) begin
                write_en = 1'b1;
                if (bp.upd_taken) begin
                    new_entry.target = bp.upd_target;
                    if (upd_entry.ctr != CTR_MAX)
                        new_entry.ctr = upd_entry.ctr + CTR_W'(1);
                end else if (upd_entry.ctr != '0) begin
                    new_entry.ctr = upd_entry.ctr - CTR_W'(1);
                end
            end else if (bp.upd_taken) begin
                // Miss on a taken branch allocates (or evicts) as weakly taken;
                // a not-taken miss leaves the table alone.
                write_en  = 1'b1;
                new_entry = '{valid: 1'b1, tag: upd_tag, target: bp.upd_target,
                              ctr: CTR_WEAK_T};
            end
        end
    end

    // ---------------- state --------------------------------------------------
    // NOTE: the table is flops, not RAM, so it is reset in one cycle; a flush
    // must forget every learned entry. Sequential state uses <= only.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < ENTRIES; i++)
                btb_q[i] <= ENTRY_RST;
        end else if (write_en) begin
            btb_q[upd_idx] <= new_entry;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            stat_lookups_q <= '0;
            stat_mispred_q <= '0;
        end else begin
            if (bp.upd_valid && (stat_lookups_q != '1))
                stat_lookups_q <= stat_lookups_q + STAT_W'(1);
            if (bp.mispredict && (stat_mispred_q != '1))
                stat_mispred_q <= stat_mispred_q + STAT_W'(1);
        end
    end

    assign bp.stat_lookups = stat_lookups_q;
    assign bp.stat_mispred = stat_mispred_q;
endmodule

// File: tb/tb_branch_predictor.sv
// ----------------------------------------------------------------------------
// tb_branch_predictor
//   Directed-vector bench for branch_predictor (ENTRIES=16, CTR_W=2,
//   STAT_W=4). Inputs change 1 time unit after the rising edge; outputs are
//   sampled on the falling edge.
// ----------------------------------------------------------------------------
module tb_branch_predictor;
    logic CLK = 1'b0;
    logic RST;

    int checks = 0;
    int errors = 0;

    branch_predictor_if #(.STAT_W(4)) bp ();

    branch_predictor #(.ENTRIES(16), .CTR_W(2), .STAT_W(4)) dut (
        .CLK (CLK),
        .RST (RST),
        .bp  (bp)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Fetch lookup; consumes one cycle, returns just after the next rising edge.
    task automatic lookup(input string tag, input logic [31:0] pc,
                          input logic hit, input logic taken, input logic [31:0] npc);
        bp.if_pc = pc;
        @(negedge CLK);
        check({tag, ".hit"},   32'(bp.pred_hit),   32'(hit));
        check({tag, ".taken"}, 32'(bp.pred_taken), 32'(taken));
        check({tag, ".npc"},   bp.pred_npc,        npc);
        @(posedge CLK);
        #1;
    endtask

    // One resolved control instruction; table/stat update lands on the edge.
    task automatic resolve(input string tag, input logic [31:0] pc, input logic taken,
                           input logic [31:0] target, input logic ptaken,
                           input logic [31:0] pnpc, input logic exp_mis,
                           input logic [31:0] exp_redir);
        bp.upd_valid      = 1'b1;
        bp.upd_pc         = pc;
        bp.upd_taken      = taken;
        bp.upd_target     = target;
        bp.upd_pred_taken = ptaken;
        bp.upd_pred_npc   = pnpc;
        @(negedge CLK);
        check({tag, ".mis"},   32'(bp.mispredict), 32'(exp_mis));
        check({tag, ".redir"}, bp.redirect_pc,     exp_redir);
        @(posedge CLK);
        #1;
        bp.upd_valid = 1'b0;
    endtask

    initial begin
        RST               = 1'b1;
        bp.if_pc          = '0;
        bp.upd_valid      = 1'b0;
        bp.upd_pc         = '0;
        bp.upd_taken      = 1'b0;
        bp.upd_target     = '0;
        bp.upd_pred_taken = 1'b0;
        bp.upd_pred_npc   = '0;
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b0;

        // Reset state
        @(negedge CLK);
        check("rst.lookups", 32'(bp.stat_lookups), 32'd0);
        check("rst.mispred", 32'(bp.stat_mispred), 32'd0);
        check("rst.mis",     32'(bp.mispredict),   32'd0);
        @(posedge CLK);
        #1;
        lookup("rst_lu", 32'h40, 1'b0, 1'b0, 32'h44);

        // Allocate on taken miss (ctr=2)
        resolve("alloc", 32'h40, 1'b1, 32'h100, 1'b0, 32'h44, 1'b1, 32'h100);
        lookup("alloc_lu", 32'h40, 1'b1, 1'b1, 32'h100);

        // Counter walks down 2->1->0 and stays at 0
        resolve("nt1", 32'h40, 1'b0, 32'h100, 1'b1, 32'h100, 1'b1, 32'h44);
        lookup("nt1_lu", 32'h40, 1'b1, 1'b0, 32'h44);
        resolve("nt2", 32'h40, 1'b0, 32'h100, 1'b0, 32'h44, 1'b0, 32'h44);
        resolve("nt3", 32'h40, 1'b0, 32'h100, 1'b0, 32'h44, 1'b0, 32'h44);
        resolve("t1",  32'h40, 1'b1, 32'h100, 1'b0, 32'h44, 1'b1, 32'h100);
        lookup("t1_lu", 32'h40, 1'b1, 1'b0, 32'h44);            // ctr=1
        // Correct direction but wrong target still mispredicts; ctr 1->2
        resolve("tgt", 32'h40, 1'b1, 32'h100, 1'b1, 32'h104, 1'b1, 32'h100);
        // Hit+taken retargets; ctr 2->3 then saturates at 3
        resolve("retgt", 32'h40, 1'b1, 32'h200, 1'b1, 32'h100, 1'b1, 32'h200);
        resolve("sat3",  32'h40, 1'b1, 32'h200, 1'b1, 32'h200, 1'b0, 32'h200);
        resolve("dn2",   32'h40, 1'b0, 32'h200, 1'b1, 32'h200, 1'b1, 32'h44);
        lookup("dn2_lu", 32'h40, 1'b1, 1'b1, 32'h200);          // ctr=2
        // 9 resolutions so far, 6 of them mispredicted
        check("mid.lookups", 32'(bp.stat_lookups), 32'd9);
        check("mid.mispred", 32'(bp.stat_mispred), 32'd6);

        // Aliasing at index 0: 0x80 evicts 0x40; not-taken miss 0xC0 is ignored
        resolve("alias", 32'h80, 1'b1, 32'h300, 1'b0, 32'h84, 1'b1, 32'h300);
        lookup("alias_40", 32'h40, 1'b0, 1'b0, 32'h44);
        lookup("alias_80", 32'h80, 1'b1, 1'b1, 32'h300);
        resolve("ntmiss", 32'hC0, 1'b0, 32'h999, 1'b0, 32'hC4, 1'b0, 32'hC4);
        lookup("ntmiss_80", 32'h80, 1'b1, 1'b1, 32'h300);
        lookup("ntmiss_c0", 32'hC0, 1'b0, 1'b0, 32'hC4);

        // Same-cycle update and lookup: old state now, new state next cycle
        bp.if_pc          = 32'h44;
        bp.upd_valid      = 1'b1;
        bp.upd_pc         = 32'h44;
        bp.upd_taken      = 1'b1;
        bp.upd_target     = 32'h500;
        bp.upd_pred_taken = 1'b0;
        bp.upd_pred_npc   = 32'h48;
        @(negedge CLK);
        check("byp.old_hit", 32'(bp.pred_hit), 32'd0);
        check("byp.old_npc", bp.pred_npc,      32'h48);
        @(posedge CLK);
        #1;
        bp.upd_valid = 1'b0;
        lookup("byp_new", 32'h44, 1'b1, 1'b1, 32'h500);

        // PC+4 wraps at the top of the address space
        lookup("wrap_lu", 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0);
        resolve("wrap_up", 32'hFFFF_FFFC, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);

        // Statistics saturate at 15 with STAT_W=4
        for (int i = 0; i < 20; i++)
            resolve("sat", 32'h1000 + 32'(i * 4), 1'b1, 32'h700, 1'b0,
                    32'h1004 + 32'(i * 4), 1'b1, 32'h700);
        @(negedge CLK);
        check("sat.mispred", 32'(bp.stat_mispred), 32'd15);
        check("sat.lookups", 32'(bp.stat_lookups), 32'd15);
        @(posedge CLK);
        #1;

        // Reset mid-run with a taken update pending: reset wins
        RST               = 1'b1;
        bp.upd_valid      = 1'b1;
        bp.upd_pc         = 32'h2000;
        bp.upd_taken      = 1'b1;
        bp.upd_target     = 32'h600;
        bp.upd_pred_taken = 1'b0;
        bp.upd_pred_npc   = 32'h2004;
        @(posedge CLK);
        #1;
        RST          = 1'b0;
        bp.upd_valid = 1'b0;
        @(negedge CLK);
        check("rst2.lookups", 32'(bp.stat_lookups), 32'd0);
        check("rst2.mispred", 32'(bp.stat_mispred), 32'd0);
        @(posedge CLK);
        #1;
        lookup("rst2_80",   32'h80,   1'b0, 1'b0, 32'h84);
        lookup("rst2_1000", 32'h1000, 1'b0, 1'b0, 32'h1004);
        lookup("rst2_2000", 32'h2000, 1'b0, 1'b0, 32'h2004);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
